// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: ALU select codes, command opcodes
// and sequencer states.
package alu_pkg;

  localparam logic [3:0] ALU_SUB = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAnd  = 3'd2,
    OpXor  = 3'd3,
    OpCmp  = 3'd4,
    OpMul  = 3'd5,
    OpIll6 = 3'd6,
    OpIll7 = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMulStep,
    StResp
  } seq_state_e;

  // CMP is a subtraction whose result is discarded.
  function automatic logic [3:0] alu_sel(input cmd_op_e op);
    case (op)
      OpAdd:   return ALU_ADD;
      OpAnd:   return ALU_AND;
      OpXor:   return ALU_XOR;
      default: return ALU_SUB;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_datapath.sv
// Shift-add multiply state: accumulator, shifting multiplicand/multiplier, step counter
// and the sticky carry collected over all ALU add passes.
module alu_mul_datapath #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MUL_STEPS = WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  input  logic [WIDTH-1:0] i_alu_y,
  input  logic             i_alu_carry,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_addend,
  output logic             o_last,
  output logic             o_carry_next
);

  localparam int unsigned StepW = $clog2(MUL_STEPS + 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [StepW-1:0] r_step;
  logic             r_carry;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_step   <= '0;
      r_carry  <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_step   <= '0;
      r_carry  <= 1'b0;
    end else if (i_step) begin
      r_acc    <= i_alu_y;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_step   <= r_step + 1'b1;
      r_carry  <= r_carry | i_alu_carry;
    end
  end

  assign o_acc        = r_acc;
  assign o_addend     = r_mplier[0] ? r_mcand : '0;
  assign o_last       = (r_step == StepW'(MUL_STEPS - 1));
  assign o_carry_next = r_carry | i_alu_carry;

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side driver for the combinational ALU: accepts commands, runs one ALU pass
// (or a shift-add MUL loop) and returns result and flags over a valid/ready channel.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MUL_STEPS = WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [3:0]       o_alu_s,
  input  logic [WIDTH-1:0] i_alu_y,
  input  logic             i_alu_zero,
  input  logic             i_alu_carry,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_zero,
  output logic             o_rsp_carry,
  output logic             o_rsp_err
);

  seq_state_e       r_state;
  cmd_op_e          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_carry;
  logic             r_rsp_err;

  cmd_op_e          w_cmd_op;
  logic             w_accept;
  logic             w_mul_start;
  logic             w_mul_step;
  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_addend;
  logic             w_mul_last;
  logic             w_carry_next;

  assign w_cmd_op    = cmd_op_e'(i_cmd_op);
  assign o_cmd_ready = (r_state == StIdle) && !i_reset;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_mul_start = w_accept && (w_cmd_op == OpMul);
  assign w_mul_step  = (r_state == StMulStep);

  alu_mul_datapath #(
    .WIDTH     (WIDTH),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (w_mul_start),
    .i_step       (w_mul_step),
    .i_mcand      (i_cmd_a),
    .i_mplier     (i_cmd_b),
    .i_alu_y      (i_alu_y),
    .i_alu_carry  (i_alu_carry),
    .o_acc        (w_acc),
    .o_addend     (w_addend),
    .o_last       (w_mul_last),
    .o_carry_next (w_carry_next)
  );

  always_comb begin
    o_alu_a = '0;
    o_alu_b = '0;
    o_alu_s = ALU_SUB;
    case (r_state)
      StExec: begin
        o_alu_a = r_a;
        o_alu_b = r_b;
        o_alu_s = alu_sel(r_op);
      end
      StMulStep: begin
        o_alu_a = w_acc;
        o_alu_b = w_addend;
        o_alu_s = ALU_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_op        <= OpAdd;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_op <= w_cmd_op;
            r_a  <= i_cmd_a;
            r_b  <= i_cmd_b;
            case (w_cmd_op)
              OpMul: r_state <= StMulStep;
              OpIll6, OpIll7: begin
                r_state     <= StResp;
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_zero  <= 1'b0;
                r_rsp_carry <= 1'b0;
                r_rsp_err   <= 1'b1;
              end
              default: r_state <= StExec;
            endcase
          end
        end
        StExec: begin
          r_state     <= StResp;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_zero  <= i_alu_zero;
          r_rsp_data  <= i_alu_y;
          case (r_op)
            OpAdd: r_rsp_carry <= i_alu_carry;
            OpSub: r_rsp_carry <= (r_a < r_b);
            OpCmp: begin
              r_rsp_carry <= (r_a < r_b);
              r_rsp_data  <= '0;
            end
            default: r_rsp_carry <= 1'b0;
          endcase
        end
        StMulStep: begin
          if (w_mul_last) begin
            r_state     <= StResp;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= i_alu_y;
            r_rsp_zero  <= (i_alu_y == '0);
            r_rsp_carry <= w_carry_next;
          end
        end
        StResp: begin
          if (i_rsp_ready) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_zero  = r_rsp_zero;
  assign o_rsp_carry = r_rsp_carry;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side driver for the 32-bit combinational ALU. It accepts operation commands over a valid/ready handshake and drives the ALU operand and select inputs. It captures the ALU result and flags, then returns them over a valid/ready response channel. It also sequences a multi-cycle MUL as repeated ALU ADD passes, using shift-add.

Parameters:
WIDTH, 32, operand, result and ALU datapath width.
MUL_STEPS, WIDTH, number of shift-add iterations per MUL. Fixed, with no early exit.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_op  in  3  0 ADD, 1 SUB, 2 AND, 3 XOR, 4 CMP, 5 MUL, 6-7 illegal.
cmd_a  in  WIDTH  operand A (multiplicand for MUL).
cmd_b  in  WIDTH  operand B (multiplier for MUL).
alu_a  out  WIDTH  to ALU A.
alu_b  out  WIDTH  to ALU B.
alu_s  out  4  ALU select: 0000 SUB, 0010 ADD, 0011 AND, 0100 XOR.
alu_y  in  WIDTH  ALU result.
alu_zero  in  1  ALU result == 0.
alu_carry  in  1  carry-out of A+B; always the add carry, whatever alu_s is.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rsp_data  out  WIDTH  result (0 for CMP and for illegal ops).
rsp_zero  out  1  zero flag.
rsp_carry  out  1  carry or borrow flag (see below).
rsp_err  out  1  illegal opcode.

Behaviour:
- States:
  - IDLE: accept a command.
  - EXEC: one ALU pass.
  - MUL_STEP: shift-add loop.
  - RESP: hold the response.
- cmd_ready = (state==IDLE) && !reset. A command is accepted on the edge where cmd_valid && cmd_ready.
- On accept:
  - Latch op, a and b.
  - Ops 0-4 go to EXEC; op 5 goes to MUL_STEP with acc=0, step=0; ops 6-7 go directly to RESP.
- EXEC (one cycle):
  - Drive alu_a=a, alu_b=b and alu_s per op. CMP uses SUB.
  - Sample alu_y and alu_zero at the end of the cycle, then go to RESP.
- Carry rules:
  - ADD: rsp_carry = alu_carry.
  - SUB and CMP: rsp_carry = borrow = (a < b unsigned), computed internally.
  - AND and XOR: rsp_carry = 0.
- CMP: rsp_data = 0; rsp_zero = alu_zero (operands equal).
- MUL_STEP, per step:
  - Drive alu_s=ADD and alu_a=acc.
  - Drive alu_b = mcand if mplier[0], else 0.
  - Update acc <= alu_y; mcand <<= 1; mplier >>= 1; step++.
  - rsp_carry is the sticky OR of alu_carry over all steps.
  - After MUL_STEPS steps go to RESP, with rsp_data = low WIDTH bits of the product and rsp_zero = (acc == 0), computed internally.
  - Product bits lost by the mcand shift are not flagged.
- Latency from the accept edge to rsp_valid high:
  - Ops 0-4: 2 cycles.
  - MUL: MUL_STEPS+1 cycles.
  - Illegal ops: 1 cycle, with rsp_err=1, data 0, zero 0, carry 0.
- RESP:
  - rsp_valid=1, and all rsp_* outputs are held stable until rsp_valid && rsp_ready.
  - Then return to IDLE. The next command can be accepted in the following cycle; there is no back-to-back accept in the handshake cycle.
- ALU drive outside EXEC and MUL_STEP: alu_a=0, alu_b=0, alu_s=0000.
- Reset:
  - Any state goes to IDLE.
  - rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err, alu_a, alu_b, alu_s and all internal registers go to 0.
  - An in-flight operation is discarded and no response is produced.
  - cmd_valid is ignored while reset is high.
- cmd_* inputs are don't-care outside the accept edge.

Decomposition:
- Shared package alu_pkg:
  - ALU select constants: ALU_SUB=4'b0000, ALU_ADD=4'b0010, ALU_AND=4'b0011, ALU_XOR=4'b0100.
  - cmd_op enum.
  - Sequencer state enum.
- One natural sub-module, alu_mul_datapath: the acc/mcand/mplier/step registers and the sticky carry, with start and done signals. The FSM and handshakes stay in the top.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001 -> rsp_data=0, zero=1, carry=1, err=0; rsp_valid 2 cycles after accept.
- SUB a=5, b=7 -> rsp_data=0xFFFFFFFE, zero=0, carry=1. CMP a=7, b=7 -> rsp_data=0, zero=1, carry=0.
- MUL cases, each with rsp_valid exactly 33 cycles after accept:
  - 0x00001234 * 0x00000010 -> data 0x00012340, zero=0, carry=0.
  - 0xFFFFFFFF * 3 -> data 0xFFFFFFFD, carry=1.
  - 0x80000000 * 2 -> data 0, zero=1, carry=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after an XOR (a=0xF0F0F0F0, b=0xFFFF0000 -> data 0x0F0FF0F0):
  - rsp_* stable and cmd_ready=0 throughout.
  - A second pending command is accepted in the cycle after the rsp handshake.
- Reset asserted for 1 cycle at MUL step 10:
  - Next cycle rsp_valid=0, alu_* = 0, cmd_ready=1 after deassert.
  - A following ADD 2+3 returns 5 with zero=0, carry=0.
- Illegal op 6 -> rsp_valid 1 cycle after accept, rsp_err=1, data 0, no non-zero alu_s driven.
